// File: rtl/alu_seq_param.sv
// Registered multi-cycle ALU: single-cycle logic ops plus iterative MUL/DIVU.
// Optional Overflow output when ALU_SEQ_OVERFLOW_EN is defined.
module alu_seq_param #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Hi,
    output logic             Zero
`ifdef ALU_SEQ_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SGT  = 4'd11;
    localparam logic [3:0] OP_ROTR = 4'd13;
    localparam logic [3:0] OP_SLTU = 4'd14;
    localparam logic [3:0] OP_DIVU = 4'd15;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_FINISH
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;

    // Single-cycle datapath, evaluated straight from the Start-cycle operands
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] rot_w;
    logic [WIDTH-1:0]   add_res, sub_res;
    logic [WIDTH-1:0]   alu_res, alu_hi;

    assign sh      = B[SHW-1:0];
    assign rot_w   = {A, A} >> sh;
    assign add_res = A + B;
    assign sub_res = A - B;

    always_comb begin
        alu_res = '0;
        alu_hi  = '0;
        case (ALUControl)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_ADD:  alu_res = add_res;
            OP_NOR:  alu_res = ~(A | B);
            OP_XOR:  alu_res = A ^ B;
            OP_SUB:  alu_res = sub_res;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, A < B};
            OP_SGT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) > $signed(B)};
            OP_SLL:  alu_res = A << sh;
            OP_ROTR: alu_res = rot_w[WIDTH-1:0];
            OP_DIVU: begin
                alu_res = '1;
                alu_hi  = A;
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_OVERFLOW_EN
    logic ovf_q, ovf_d;
    logic alu_ovf;

    always_comb begin
        alu_ovf = 1'b0;
        if (ALUControl == OP_ADD)
            alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                      (add_res[WIDTH-1] != A[WIDTH-1]);
        else if (ALUControl == OP_SUB)
            alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                      (sub_res[WIDTH-1] != A[WIDTH-1]);
    end
`endif

    // Shift-add multiply: acc_lo holds the multiplier, opb the multiplicand
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;

    assign mul_sum = {1'b0, acc_hi_q} +
                     {1'b0, (acc_lo_q[0] ? opb_q : {WIDTH{1'b0}})};
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    // Restoring divide: acc_hi is the partial remainder, acc_lo the dividend
    logic [WIDTH:0]   div_trial;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi, div_lo;

    assign div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opb_q};
    assign div_ok    = ~div_trial[WIDTH];
    assign div_hi    = div_ok ? div_trial[WIDTH-1:0]
                              : {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
    assign div_lo    = {acc_lo_q[WIDTH-2:0], div_ok};

    logic [WIDTH-1:0] step_hi, step_lo;

    assign step_hi = (op_q == OP_MUL) ? mul_hi : div_hi;
    assign step_lo = (op_q == OP_MUL) ? mul_lo : div_lo;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opb_d    = opb_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
`ifdef ALU_SEQ_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d  = ALUControl;
                    cnt_d = '0;
                    if (ALUControl == OP_MUL) begin
                        state_d  = S_EXEC;
                        opb_d    = A;
                        acc_hi_d = '0;
                        acc_lo_d = B;
                    end else if (ALUControl == OP_DIVU && B != '0) begin
                        state_d  = S_EXEC;
                        opb_d    = B;
                        acc_hi_d = '0;
                        acc_lo_d = A;
                    end else begin
                        state_d  = S_FINISH;
                        result_d = alu_res;
                        hi_d     = alu_hi;
                        zero_d   = (alu_res == '0);
`ifdef ALU_SEQ_OVERFLOW_EN
                        ovf_d    = alu_ovf;
`endif
                    end
                end
            end
            S_EXEC: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_FINISH;
                    result_d = step_lo;
                    hi_d     = step_hi;
                    zero_d   = (step_lo == '0);
`ifdef ALU_SEQ_OVERFLOW_EN
                    ovf_d    = 1'b0;
`endif
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            opb_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b1;
`ifdef ALU_SEQ_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opb_q    <= opb_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
`ifdef ALU_SEQ_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign Busy   = (state_q != S_IDLE);
    assign Done   = (state_q == S_FINISH);
    assign Result = result_q;
    assign Hi     = hi_q;
    assign Zero   = zero_q;
`ifdef ALU_SEQ_OVERFLOW_EN
    assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed self-checking bench for alu_seq_param at WIDTH = 32.
module tb_alu_seq_param;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         Start = 1'b0;
    logic [3:0]   ALUControl = 4'd0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Busy, Done, Zero;
    logic [W-1:0] Result, Hi;
`ifdef ALU_SEQ_OVERFLOW_EN
    logic         Overflow;
`endif

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    alu_seq_param #(.WIDTH(W), .SHW(5)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .Busy       (Busy),
        .Done       (Done),
        .Result     (Result),
        .Hi         (Hi),
        .Zero       (Zero)
`ifdef ALU_SEQ_OVERFLOW_EN
        ,
        .Overflow   (Overflow)
`endif
    );

    localparam int NT = 16;
    localparam logic [3:0] T_OP [NT] = '{
        4'd0, 4'd1, 4'd4, 4'd3, 4'd2, 4'd6, 4'd10, 4'd11,
        4'd7, 4'd14, 4'd13, 4'd13, 4'd11, 4'd5, 4'd8, 4'd12
    };
    localparam logic [W-1:0] T_A [NT] = '{
        32'hF0F01234, 32'hF0F01234, 32'hF0F01234, 32'hF0F01234,
        32'hF0F01234, 32'hF0F01234, 32'hF0F01234, 32'hF0F01234,
        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hF0F01234,
        32'h00000001, 32'hF0F01234, 32'hF0F01234, 32'hF0F01234
    };
    localparam logic [W-1:0] T_B [NT] = '{
        32'h0FF00004, 32'h0FF00004, 32'h0FF00004, 32'h0FF00004,
        32'h0FF00004, 32'h0FF00004, 32'h0FF00004, 32'h0FF00004,
        32'h00000001, 32'h00000001, 32'd33,       32'h0FF00004,
        32'hFFFFFFFF, 32'h0FF00004, 32'h0FF00004, 32'h0FF00004
    };
    localparam logic [W-1:0] T_R [NT] = '{
        32'h00F00004, 32'hFFF01234, 32'hFF001230, 32'h000FEDCB,
        32'h00E01238, 32'hE1001230, 32'h0F012340, 32'h00000000,
        32'h00000001, 32'h00000000, 32'h80000000, 32'h4F0F0123,
        32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000
    };

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Issues one operation from the current cycle and waits for Done.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int lat,
                         output int busy);
        Start = 1'b1;
        ALUControl = op;
        A = a;
        B = b;
        step();
        Start = 1'b0;
        ALUControl = 4'($urandom);
        A = $urandom;
        B = $urandom;
        lat = 1;
        busy = 0;
        while (Done !== 1'b1 && lat < 100) begin
            if (Busy === 1'b1) busy++;
            step();
            lat++;
        end
        if (Busy === 1'b1) busy++;
        if (Done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        Start = 1'b0;
        repeat (3) step();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl busy=%b done=%b exp 0 0", Busy, Done);
        end
        checks++;
        if (Result !== '0 || Hi !== '0 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_out res=%h hi=%h zero=%b exp 0 0 1",
                     Result, Hi, Zero);
        end
        Rst = 1'b1;
        step();
    endtask

    task automatic test_add();
        int lat, busy;
        do_op(4'd2, 32'h7FFFFFFF, 32'h1, lat, busy);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL add_lat got=%0d exp=1", lat);
        end
        checks++;
        if (Result !== 32'h80000000 || Hi !== '0 || Zero !== 1'b0) begin
            failures++;
            $display("FAIL add_out res=%h hi=%h zero=%b exp 80000000 0 0",
                     Result, Hi, Zero);
        end
`ifdef ALU_SEQ_OVERFLOW_EN
        checks++;
        if (Overflow !== 1'b1) begin
            failures++;
            $display("FAIL add_ovf got=%b exp=1", Overflow);
        end
`endif
        step();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || Result !== 32'h80000000) begin
            failures++;
            $display("FAIL add_hold done=%b busy=%b res=%h exp 0 0 80000000",
                     Done, Busy, Result);
        end
`ifdef ALU_SEQ_OVERFLOW_EN
        do_op(4'd6, 32'h80000000, 32'h1, lat, busy);
        checks++;
        if (Overflow !== 1'b1 || Result !== 32'h7FFFFFFF) begin
            failures++;
            $display("FAIL sub_ovf ovf=%b res=%h exp 1 7fffffff",
                     Overflow, Result);
        end
        step();
        do_op(4'd2, 32'h1, 32'h1, lat, busy);
        checks++;
        if (Overflow !== 1'b0) begin
            failures++;
            $display("FAIL add_noovf got=%b exp=0", Overflow);
        end
        step();
`endif
    endtask

    task automatic test_single();
        int lat, busy;
        for (int i = 0; i < NT; i++) begin
            do_op(T_OP[i], T_A[i], T_B[i], lat, busy);
            checks++;
            if (lat !== 1 || Result !== T_R[i] || Hi !== '0 ||
                Zero !== (T_R[i] == '0)) begin
                failures++;
                $display("FAIL single_%0d op=%0d lat=%0d res=%h hi=%h zero=%b exp lat=1 res=%h hi=0",
                         i, T_OP[i], lat, Result, Hi, Zero, T_R[i]);
            end
            step();
        end
    endtask

    task automatic test_mul();
        int lat, busy;
        do_op(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy);
        checks++;
        if (lat !== 33 || busy !== 33) begin
            failures++;
            $display("FAIL mul_lat lat=%0d busy=%0d exp 33 33", lat, busy);
        end
        checks++;
        if (Hi !== 32'hFFFFFFFE || Result !== 32'h1 || Zero !== 1'b0) begin
            failures++;
            $display("FAIL mul_max hi=%h res=%h zero=%b exp fffffffe 1 0",
                     Hi, Result, Zero);
        end
        step();
        do_op(4'd9, 32'h80000000, 32'h4, lat, busy);
        checks++;
        if (Hi !== 32'h2 || Result !== '0 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL mul_hi hi=%h res=%h zero=%b exp 2 0 1",
                     Hi, Result, Zero);
        end
        step();
    endtask

    task automatic test_divu();
        int lat, busy;
        do_op(4'd15, 32'd100, 32'd7, lat, busy);
        checks++;
        if (lat !== 33 || Result !== 32'd14 || Hi !== 32'd2) begin
            failures++;
            $display("FAIL div_100_7 lat=%0d res=%h hi=%h exp 33 e 2",
                     lat, Result, Hi);
        end
        step();
        do_op(4'd15, 32'd5, 32'd0, lat, busy);
        checks++;
        if (lat !== 1 || Result !== 32'hFFFFFFFF || Hi !== 32'd5) begin
            failures++;
            $display("FAIL div_by0 lat=%0d res=%h hi=%h exp 1 ffffffff 5",
                     lat, Result, Hi);
        end
        step();
        do_op(4'd15, 32'd7, 32'd100, lat, busy);
        checks++;
        if (Result !== '0 || Hi !== 32'd7 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL div_small res=%h hi=%h zero=%b exp 0 7 1",
                     Result, Hi, Zero);
        end
        step();
        do_op(4'd15, 32'hFFFFFFFF, 32'h10, lat, busy);
        checks++;
        if (Result !== 32'h0FFFFFFF || Hi !== 32'hF) begin
            failures++;
            $display("FAIL div_big res=%h hi=%h exp 0fffffff f", Result, Hi);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int lat, busy;
        Start = 1'b1;
        ALUControl = 4'd9;
        A = 32'd6;
        B = 32'd7;
        step();
        Start = 1'b0;
        lat = 1;
        repeat (5) begin
            step();
            lat++;
        end
        Start = 1'b1;
        ALUControl = 4'd6;
        A = 32'd9;
        B = 32'd1;
        step();
        lat++;
        Start = 1'b0;
        while (Done !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== 33 || Result !== 32'd42 || Hi !== '0) begin
            failures++;
            $display("FAIL ignore_start lat=%0d res=%h hi=%h exp 33 2a 0",
                     lat, Result, Hi);
        end
        step();
        do_op(4'd6, 32'd3, 32'd3, lat, busy);
        checks++;
        if (lat !== 1 || Result !== '0 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL b2b_sub lat=%0d res=%h zero=%b exp 1 0 1",
                     lat, Result, Zero);
        end
        step();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle done=%b busy=%b exp 0 0", Done, Busy);
        end
    endtask

    task automatic test_reset_abort();
        int lat, busy, seen;
        do_op(4'd9, 32'd3, 32'h80000001, lat, busy);
        checks++;
        if (Hi !== 32'h1 || Result !== 32'h80000003) begin
            failures++;
            $display("FAIL pre_abort hi=%h res=%h exp 1 80000003", Hi, Result);
        end
        step();
        Start = 1'b1;
        ALUControl = 4'd15;
        A = 32'd100;
        B = 32'd7;
        step();
        Start = 1'b0;
        repeat (10) step();
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Result !== '0 ||
            Hi !== '0 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL abort busy=%b done=%b res=%h hi=%h zero=%b exp 0 0 0 0 1",
                     Busy, Done, Result, Hi, Zero);
        end
`ifdef ALU_SEQ_OVERFLOW_EN
        checks++;
        if (Overflow !== 1'b0) begin
            failures++;
            $display("FAIL abort_ovf got=%b exp=0", Overflow);
        end
`endif
        seen = 0;
        repeat (40) begin
            step();
            if (Done === 1'b1 || Busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_no_done active_cycles=%0d exp=0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_single();
        test_mul();
        test_divu();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
